// File: rtl/coin_drop_animator.sv
// Animates a 4x4 coin falling one pixel per frame on the 160x120 VGA adapter.
// Optional build macro COIN_DROP_COUNT_EN adds a saturating count of coins that reached the bottom.
module coin_drop_animator #(
  parameter int unsigned FRAME_DIV   = 833333,
  parameter logic [6:0]  Y_LIMIT     = 7'd116,
  parameter logic [7:0]  X_LIMIT     = 8'd156,
  parameter logic [2:0]  COIN_COLOUR = 3'b110,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] ix_loc,
  input  logic [6:0] iy_loc,
  input  logic       collect,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
`ifdef COIN_DROP_COUNT_EN
  output logic [7:0] coins_dropped,
`endif
  output logic       coin_done,
  output logic       coin_caught
);

  localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_STEP,
    S_DONE
  } state_t;

  state_t           state;
  logic [7:0]       cur_x;
  logic [6:0]       cur_y;
  logic [3:0]       pix;
  logic [CNT_W-1:0] frame_cnt;
  logic             caught;

  logic [3:0]       pix_nxt;
  logic [7:0]       x_clamped;

  always_comb begin
    pix_nxt   = pix + 4'd1;
    x_clamped = (ix_loc > X_LIMIT) ? X_LIMIT : ix_loc;
  end

  // Outputs are registered from the values being loaded on each transition,
  // so they always match the state that is current in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cur_x       <= '0;
      cur_y       <= '0;
      pix         <= '0;
      frame_cnt   <= '0;
      caught      <= 1'b0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      coin_done   <= 1'b0;
      coin_caught <= 1'b0;
`ifdef COIN_DROP_COUNT_EN
      coins_dropped <= '0;
`endif
    end else begin
      coin_done   <= 1'b0;
      coin_caught <= 1'b0;
      unique case (state)
        S_IDLE: begin
          plot <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state  <= S_DRAW;
            cur_x  <= x_clamped;
            cur_y  <= iy_loc;
            pix    <= '0;
            caught <= 1'b0;
            x      <= x_clamped;
            y      <= iy_loc;
            colour <= COIN_COLOUR;
            plot   <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_DRAW, S_ERASE: begin
          if (pix == 4'd15) begin
            pix  <= '0;
            plot <= 1'b0;
            if (state == S_DRAW) begin
              state     <= S_WAIT;
              frame_cnt <= '0;
            end else if (caught) begin
              state       <= S_DONE;
              coin_caught <= 1'b1;
            end else begin
              state <= S_STEP;
            end
          end else begin
            pix <= pix_nxt;
            x   <= cur_x + {6'd0, pix_nxt[1:0]};
            y   <= cur_y + {5'd0, pix_nxt[3:2]};
          end
        end
        S_WAIT: begin
          if (collect || frame_cnt == CNT_LAST) begin
            if (collect) caught <= 1'b1;
            state  <= S_ERASE;
            x      <= cur_x;
            y      <= cur_y;
            colour <= BG_COLOUR;
            plot   <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        S_STEP: begin
          if (cur_y >= Y_LIMIT) begin
            state <= S_DONE;
            if (caught) coin_caught <= 1'b1;
            else        coin_done   <= 1'b1;
          end else begin
            state  <= S_DRAW;
            cur_y  <= cur_y + 7'd1;
            x      <= cur_x;
            y      <= cur_y + 7'd1;
            colour <= COIN_COLOUR;
            plot   <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
`ifdef COIN_DROP_COUNT_EN
          if (!caught && coins_dropped != 8'hFF) coins_dropped <= coins_dropped + 8'd1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_drop_animator.sv
// Scoreboard bench for coin_drop_animator: stimulus queues expected pixel writes,
// pulses and status samples; a negedge monitor pops and compares them.
module tb_coin_drop_animator;

  localparam int unsigned FD = 4;
  localparam int unsigned P  = 33 + FD;
  localparam logic [2:0] COIN = 3'b110;
  localparam logic [2:0] BG   = 3'b000;
  localparam logic [2:0] K_PIX = 3'b100;
  localparam logic [2:0] K_DN  = 3'b010;
  localparam logic [2:0] K_CT  = 3'b001;
`ifdef COIN_DROP_COUNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       collect = 1'b0;
  logic [7:0] ix_loc = '0;
  logic [6:0] iy_loc = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, coin_done, coin_caught;
  logic [7:0] cnt_act;
`ifdef COIN_DROP_COUNT_EN
  logic [7:0] coins_dropped;
  always_comb cnt_act = coins_dropped;
`else
  always_comb cnt_act = '0;
`endif

  coin_drop_animator #(.FRAME_DIV(FD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ix_loc(ix_loc), .iy_loc(iy_loc),
    .collect(collect), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
`ifdef COIN_DROP_COUNT_EN
    .coins_dropped(coins_dropped),
`endif
    .coin_done(coin_done), .coin_caught(coin_caught)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  kind;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    int unsigned cyc;
  } ev_t;

  typedef struct {
    int unsigned cyc;
    logic        busy;
    logic        plot;
    logic        all_zero;
    logic        chk_cnt;
    logic [7:0]  cnt;
  } st_t;

  ev_t eq[$];
  st_t sq[$];
  int  checks = 0;
  int  errors = 0;
  logic mon_en = 1'b0, stop_req = 1'b0, mon_done = 1'b0;

  ev_t mon_e;
  st_t mon_s;
  logic [2:0] act_kind;

  always @(negedge clk) begin
    if (mon_en) begin
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        mon_s = sq.pop_front();
        checks++;
        if (busy !== mon_s.busy || plot !== mon_s.plot ||
            (mon_s.all_zero && (x != 0 || y != 0 || colour != 0 || coin_done || coin_caught)) ||
            (mon_s.chk_cnt && cnt_act != mon_s.cnt)) begin
          errors++;
          $display("FAIL status@%0d got busy=%0b plot=%0b x=%0d y=%0d col=%0d done=%0b caught=%0b cnt=%0d required busy=%0b plot=%0b all_zero=%0b cnt=%0d(chk=%0b)",
                   cyc, busy, plot, x, y, colour, coin_done, coin_caught, cnt_act,
                   mon_s.busy, mon_s.plot, mon_s.all_zero, mon_s.cnt, mon_s.chk_cnt);
        end
      end
      while (eq.size() > 0 && eq[0].cyc < cyc) begin
        mon_e = eq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event kind=%03b x=%0d y=%0d col=%0d required at cyc %0d, got nothing",
                 mon_e.kind, mon_e.x, mon_e.y, mon_e.colour, mon_e.cyc);
      end
      act_kind = {plot, coin_done, coin_caught};
      if (act_kind != 3'b000) begin
        checks++;
        if (eq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind=%03b x=%0d y=%0d col=%0d at cyc %0d, required none",
                   act_kind, x, y, colour, cyc);
        end else begin
          mon_e = eq.pop_front();
          if (act_kind != mon_e.kind || cyc != mon_e.cyc ||
              (mon_e.kind == K_PIX && (x != mon_e.x || y != mon_e.y || colour != mon_e.colour))) begin
            errors++;
            $display("FAIL event got kind=%03b x=%0d y=%0d col=%0d cyc=%0d required kind=%03b x=%0d y=%0d col=%0d cyc=%0d",
                     act_kind, x, y, colour, cyc, mon_e.kind, mon_e.x, mon_e.y, mon_e.colour, mon_e.cyc);
          end
        end
      end
      if (stop_req && !mon_done) begin
        checks++;
        if (eq.size() != 0 || sq.size() != 0) begin
          errors++;
          $display("FAIL leftover_expectations events=%0d status=%0d required 0 0", eq.size(), sq.size());
        end
        mon_done = 1'b1;
      end
    end
  end

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_sq(input int unsigned c, input logic b, input logic p,
                         input logic z, input logic chk, input logic [7:0] n);
    st_t s;
    s.cyc = c; s.busy = b; s.plot = p; s.all_zero = z; s.chk_cnt = chk; s.cnt = n;
    sq.push_back(s);
  endtask

  task automatic push_square(input logic [7:0] x0, input logic [6:0] y0, input logic [2:0] col,
                             input int unsigned c0, input int unsigned n);
    for (int unsigned p = 0; p < n; p++) begin
      ev_t e;
      e.kind = K_PIX;
      e.x = x0 + 8'(p % 4);
      e.y = y0 + 7'(p / 4);
      e.colour = col;
      e.cyc = c0 + p;
      eq.push_back(e);
    end
  endtask

  task automatic push_step(input logic [7:0] x0, input logic [6:0] y0, input int unsigned b);
    push_square(x0, y0, COIN, b, 16);
    push_square(x0, y0, BG, b + 16 + FD, 16);
  endtask

  task automatic push_pulse(input logic [2:0] k, input int unsigned c);
    ev_t e;
    e.kind = k; e.x = '0; e.y = '0; e.colour = '0; e.cyc = c;
    eq.push_back(e);
  endtask

  int unsigned r, a, bb, c, b5, d, s2, e0;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
    r = cyc;
    for (int unsigned i = 1; i <= 20; i++) push_sq(r + i, 1'b0, 1'b0, 1'b1, HAS_CNT, 8'd0);
    wait_cyc(r + 21);

    // Drop from (30,0): two full steps, collect outside WAIT, then reset at DRAW pix=7.
    a = cyc;
    ix_loc = 8'd30; iy_loc = 7'd0; start = 1'b1;
    push_sq(a + 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    push_step(8'd30, 7'd0, a + 1);
    push_step(8'd30, 7'd1, a + 1 + P);
    push_square(8'd30, 7'd2, COIN, a + 1 + 2 * P, 8);
    @(negedge clk); start = 1'b0;
    wait_cyc(a + 4); collect = 1'b1;
    @(negedge clk); collect = 1'b0;
    wait_cyc(a + 1 + 2 * P + 7);
    reset_n = 1'b0;
    push_sq(cyc + 1, 1'b0, 1'b0, 1'b0, HAS_CNT, 8'd0);
    push_sq(cyc + 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk); reset_n = 1'b1;
    wait_cyc(cyc + 4);

    // Bottom drop from (110,115): done exactly 75 cycles after the start edge.
    bb = cyc;
    ix_loc = 8'd110; iy_loc = 7'd115; start = 1'b1;
    push_step(8'd110, 7'd115, bb + 1);
    push_step(8'd110, 7'd116, bb + 1 + P);
    push_pulse(K_DN, bb + 75);
    push_sq(bb + 75, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    push_sq(bb + 76, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk); start = 1'b0;
    wait_cyc(bb + 80);

    // Catch at y=5 while start is held (ignored until IDLE), then clamped, wrapping drop.
    c = cyc;
    ix_loc = 8'd70; iy_loc = 7'd0; start = 1'b1;
    for (int unsigned k = 0; k < 5; k++) push_step(8'd70, 7'(k), c + 1 + k * P);
    b5 = c + 1 + 5 * P;
    push_square(8'd70, 7'd5, COIN, b5, 16);
    push_square(8'd70, 7'd5, BG, b5 + 18, 16);
    d = b5 + 34;
    push_pulse(K_CT, d);
    push_sq(d, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    s2 = d + 1;
    push_step(8'd156, 7'd126, s2 + 1);
    push_pulse(K_DN, s2 + 1 + P);
    push_sq(s2 + 2 + P, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); ix_loc = 8'd200; iy_loc = 7'd126; start = 1'b1;
    wait_cyc(b5 + 17); collect = 1'b1;
    @(negedge clk); collect = 1'b0;
    wait_cyc(s2); collect = 1'b1;
    @(negedge clk); collect = 1'b0; start = 1'b0;
    wait_cyc(s2 + P + 5);

    // Drop starting on the last legal row.
    e0 = cyc;
    ix_loc = 8'd0; iy_loc = 7'd116; start = 1'b1;
    push_step(8'd0, 7'd116, e0 + 1);
    push_pulse(K_DN, e0 + 1 + P);
    push_sq(e0 + 2 + P, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    push_sq(e0 + 3 + P, 1'b0, 1'b0, 1'b0, HAS_CNT, 8'd3);
    @(negedge clk); start = 1'b0;
    wait_cyc(e0 + P + 6);

    stop_req = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_timeout mon_done=%0b required 1", mon_done);
      $fatal(1, "monitor did not complete");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
